boot_ctrl: RTL and testbench

Program loader and run sequencer that sits directly upstream of the processor top level. It accepts 9-bit instruction words over a valid/ready stream and writes them into instruction memory. It then holds the processor's start (init) high for a fixed number of cycles and releases it. Finally it watches halt, counts run cycles and reports done/timeout, so the bench or host needs only a load stream and a go pulse.

---
 rtl/boot_ctrl_if.sv | 28 ++
 rtl/boot_ctrl.sv | 159 +++++++++++++++
 tb/tb_boot_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/boot_ctrl_if.sv
// boot_ctrl_if: program-load stream between a host/loader source and boot_ctrl.
//   load_valid  source -> sink  word valid
//   load_data   source -> sink  instruction word (W bits)
//   load_last   source -> sink  marks final word of the program
//   load_ready  sink -> source  sink can accept a word this cycle
// A beat transfers on any CLK edge where load_valid & load_ready.
interface boot_ctrl_if #(
  parameter int W = 9
);
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_last;
  logic         load_ready;

  modport master (
    output load_valid,
    output load_data,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_last,
    output load_ready
  );
endinterface

// File: rtl/boot_ctrl.sv
// boot_ctrl: program loader and run sequencer in front of the processor.
// Streams instruction words into instruction memory, holds the processor in
// init (cpu_start) for START_CYCLES cycles, then counts run cycles until halt
// or until MAX_CYCLES is reached.
//
// Ports:
//   CLK, reset_n    clock (posedge) / asynchronous active-low reset
//   load            boot_ctrl_if.slave load stream (valid/data/last/ready)
//   imem_we/addr/wdata  instruction memory write port (write on same edge)
//   cpu_start       processor init, active high
//   cpu_halt        processor halt
//   go              single-cycle re-run request (honoured in DONE only)
//   busy, done      status: LOAD/START/RUN, and DONE
//   timeout         last run ended on MAX_CYCLES
//   overflow        last load filled memory without load_last
//   prog_len        words in the loaded program (A+1 bits)
//   cycle_count     run cycles observed with halt low
module boot_ctrl #(
  parameter int          A            = 10,
  parameter int          W            = 9,
  parameter int          START_CYCLES = 2,
  parameter logic [15:0] MAX_CYCLES   = 16'hFFFF
) (
  input  logic          CLK,
  input  logic          reset_n,
  boot_ctrl_if.slave    load,
  output logic          imem_we,
  output logic [A-1:0]  imem_addr,
  output logic [W-1:0]  imem_wdata,
  output logic          cpu_start,
  input  logic          cpu_halt,
  input  logic          go,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic          overflow,
  output logic [A:0]    prog_len,
  output logic [15:0]   cycle_count
);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE} state_t;

  localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SCW-1:0] START_LAST = SCW'(START_CYCLES - 1);

  state_t          state_q;
  logic [A-1:0]    wr_ptr_q;
  logic [A:0]      prog_len_q;
  logic            overflow_q;
  logic            timeout_q;
  logic [15:0]     cycle_count_q;
  logic [SCW-1:0]  start_cnt_q;
  logic            cpu_start_q;
  logic            load_ready_q;
  logic            busy_q;
  logic            done_q;

  logic            accept;
  logic            final_beat;
  logic            to_start;
  logic [A-1:0]    wr_ptr_d;
  logic [A:0]      prog_len_d;

  assign accept     = load.load_valid & load_ready_q;
  // wr_ptr is always 0 in IDLE/DONE, so the first beat of a new load lands at
  // address 0 and an immediate load_last yields prog_len = 1.
  assign wr_ptr_d   = wr_ptr_q + A'(1);
  assign prog_len_d = {1'b0, wr_ptr_q} + (A+1)'(1);
  // The top address closes the program even without load_last.
  assign final_beat = accept & (load.load_last | ((state_q == LOAD) & (wr_ptr_q == '1)));
  // A load beat in DONE takes priority over go.
  assign to_start   = final_beat | ((state_q == DONE) & go & ~accept);

  assign imem_we         = accept;
  assign imem_addr       = wr_ptr_q;
  assign imem_wdata      = load.load_data;
  assign load.load_ready = load_ready_q;
  assign cpu_start       = cpu_start_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign timeout         = timeout_q;
  assign overflow        = overflow_q;
  assign prog_len        = prog_len_q;
  assign cycle_count     = cycle_count_q;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      prog_len_q    <= '0;
      overflow_q    <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
      start_cnt_q   <= '0;
      cpu_start_q   <= 1'b1;
      load_ready_q  <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            overflow_q <= 1'b0;
            if (!load.load_last) begin
              state_q     <= LOAD;
              wr_ptr_q    <= wr_ptr_d;
              cpu_start_q <= 1'b1;
              busy_q      <= 1'b1;
              done_q      <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (accept && !final_beat) begin
            wr_ptr_q <= wr_ptr_d;
          end
        end
        START: begin
          if (start_cnt_q == '0) begin
            state_q     <= RUN;
            cpu_start_q <= 1'b0;
          end else begin
            start_cnt_q <= start_cnt_q - SCW'(1);
          end
        end
        RUN: begin
          if (cpu_halt || (cycle_count_q == MAX_CYCLES)) begin
            state_q      <= DONE;
            timeout_q    <= ~cpu_halt;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end else begin
            cycle_count_q <= cycle_count_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Entry into START overrides the per-state updates above.
      if (to_start) begin
        if (final_beat) begin
          prog_len_q <= prog_len_d;
          overflow_q <= ~load.load_last;
        end
        state_q       <= START;
        wr_ptr_q      <= '0;
        start_cnt_q   <= START_LAST;
        cycle_count_q <= '0;
        timeout_q     <= 1'b0;
        cpu_start_q   <= 1'b1;
        load_ready_q  <= 1'b0;
        busy_q        <= 1'b1;
        done_q        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_boot_ctrl.sv
module tb_boot_ctrl;
  logic CLK = 1'b0;
  logic reset_n = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;

  // Instance 0: default geometry (A=10, MAX_CYCLES=16'hFFFF)
  boot_ctrl_if #(.W(9)) lif0 ();
  logic        imem_we0, cpu_start0, halt0, go0, busy0, done0, timeout0, overflow0;
  logic [9:0]  imem_addr0;
  logic [8:0]  imem_wdata0;
  logic [10:0] prog_len0;
  logic [15:0] cc0;

  // Instance 1: small memory and short timeout (A=3, MAX_CYCLES=20)
  boot_ctrl_if #(.W(9)) lif1 ();
  logic        imem_we1, cpu_start1, halt1, go1, busy1, done1, timeout1, overflow1;
  logic [2:0]  imem_addr1;
  logic [8:0]  imem_wdata1;
  logic [3:0]  prog_len1;
  logic [15:0] cc1;

  boot_ctrl #(.A(10), .W(9), .START_CYCLES(2), .MAX_CYCLES(16'hFFFF)) u0 (
    .CLK(CLK), .reset_n(reset_n), .load(lif0),
    .imem_we(imem_we0), .imem_addr(imem_addr0), .imem_wdata(imem_wdata0),
    .cpu_start(cpu_start0), .cpu_halt(halt0), .go(go0),
    .busy(busy0), .done(done0), .timeout(timeout0), .overflow(overflow0),
    .prog_len(prog_len0), .cycle_count(cc0)
  );

  boot_ctrl #(.A(3), .W(9), .START_CYCLES(2), .MAX_CYCLES(16'd20)) u1 (
    .CLK(CLK), .reset_n(reset_n), .load(lif1),
    .imem_we(imem_we1), .imem_addr(imem_addr1), .imem_wdata(imem_wdata1),
    .cpu_start(cpu_start1), .cpu_halt(halt1), .go(go1),
    .busy(busy1), .done(done1), .timeout(timeout1), .overflow(overflow1),
    .prog_len(prog_len1), .cycle_count(cc1)
  );

  // Scoreboards of expected memory writes: {addr, data}
  logic [18:0] exp0 [$];
  logic [11:0] exp1 [$];
  logic [18:0] e0;
  logic [11:0] e1;

  always @(negedge CLK) begin
    if (reset_n && imem_we0) begin
      checks++;
      if (exp0.size() == 0) begin
        $display("FAIL wr0_unexpected: got write addr=%0d data=%h, required no write", imem_addr0, imem_wdata0);
      end else begin
        e0 = exp0.pop_front();
        if ({imem_addr0, imem_wdata0} !== e0)
          $display("FAIL wr0: got addr=%0d data=%h, required addr=%0d data=%h", imem_addr0, imem_wdata0, e0[18:9], e0[8:0]);
        else passed++;
      end
    end
  end

  always @(negedge CLK) begin
    if (reset_n && imem_we1) begin
      checks++;
      if (exp1.size() == 0) begin
        $display("FAIL wr1_unexpected: got write addr=%0d data=%h, required no write", imem_addr1, imem_wdata1);
      end else begin
        e1 = exp1.pop_front();
        if ({imem_addr1, imem_wdata1} !== e1)
          $display("FAIL wr1: got addr=%0d data=%h, required addr=%0d data=%h", imem_addr1, imem_wdata1, e1[11:9], e1[8:0]);
        else passed++;
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (lif0.load_ready !== 1'b1) $display("FAIL rst_load_ready: got %b required 1", lif0.load_ready); else passed++;
    checks++; if (imem_we0 !== 1'b0) $display("FAIL rst_imem_we: got %b required 0", imem_we0); else passed++;
    checks++; if (imem_addr0 !== 10'd0) $display("FAIL rst_imem_addr: got %0d required 0", imem_addr0); else passed++;
    checks++; if (cpu_start0 !== 1'b1) $display("FAIL rst_cpu_start: got %b required 1", cpu_start0); else passed++;
    checks++; if ({busy0, done0, timeout0, overflow0} !== 4'b0000) $display("FAIL rst_status: got %b required 0000", {busy0, done0, timeout0, overflow0}); else passed++;
    checks++; if (prog_len0 !== 11'd0) $display("FAIL rst_prog_len: got %0d required 0", prog_len0); else passed++;
    checks++; if (cc0 !== 16'd0) $display("FAIL rst_cycle_count: got %0d required 0", cc0); else passed++;
    checks++; if (cpu_start1 !== 1'b1 || lif1.load_ready !== 1'b1) $display("FAIL rst_u1: got start=%b ready=%b required 1 1", cpu_start1, lif1.load_ready); else passed++;
    reset_n = 1'b1;
  endtask

  task automatic test_load();
    logic [8:0] words [4];
    words = '{9'h0A1, 9'h0B2, 9'h0C3, 9'h1FF};
    for (int i = 0; i < 4; i++) begin
      lif0.load_valid = 1'b1;
      lif0.load_data  = words[i];
      lif0.load_last  = (i == 3);
      exp0.push_back({10'(i), words[i]});
      @(posedge CLK); #1;
    end
    lif0.load_valid = 1'b0;
    lif0.load_last  = 1'b0;
    checks++; if (prog_len0 !== 11'd4) $display("FAIL load_prog_len: got %0d required 4", prog_len0); else passed++;
    checks++; if (cpu_start0 !== 1'b1 || busy0 !== 1'b1) $display("FAIL load_start1: got start=%b busy=%b required 1 1", cpu_start0, busy0); else passed++;
    checks++; if (lif0.load_ready !== 1'b0) $display("FAIL load_ready_start: got %b required 0", lif0.load_ready); else passed++;
    checks++; if (overflow0 !== 1'b0) $display("FAIL load_overflow: got %b required 0", overflow0); else passed++;
    @(posedge CLK); #1;
    checks++; if (cpu_start0 !== 1'b1) $display("FAIL load_start2: got %b required 1", cpu_start0); else passed++;
    @(posedge CLK); #1;
    checks++; if (cpu_start0 !== 1'b0 || busy0 !== 1'b1) $display("FAIL load_run: got start=%b busy=%b required 0 1", cpu_start0, busy0); else passed++;
  endtask

  task automatic test_halt();
    repeat (37) @(posedge CLK);
    #1;
    checks++; if (cc0 !== 16'd37 || done0 !== 1'b0) $display("FAIL halt_pre: got count=%0d done=%b required 37 0", cc0, done0); else passed++;
    halt0 = 1'b1;
    @(posedge CLK); #1;
    halt0 = 1'b0;
    checks++; if (done0 !== 1'b1 || busy0 !== 1'b0) $display("FAIL halt_done: got done=%b busy=%b required 1 0", done0, busy0); else passed++;
    checks++; if (timeout0 !== 1'b0) $display("FAIL halt_timeout: got %b required 0", timeout0); else passed++;
    checks++; if (cc0 !== 16'd37) $display("FAIL halt_count: got %0d required 37", cc0); else passed++;
    checks++; if (lif0.load_ready !== 1'b1 || cpu_start0 !== 1'b0) $display("FAIL halt_ready: got ready=%b start=%b required 1 0", lif0.load_ready, cpu_start0); else passed++;
  endtask

  task automatic test_go();
    go0 = 1'b1;
    @(posedge CLK); #1;
    go0 = 1'b0;
    checks++; if (cpu_start0 !== 1'b1 || done0 !== 1'b0 || busy0 !== 1'b1) $display("FAIL go_start: got start=%b done=%b busy=%b required 1 0 1", cpu_start0, done0, busy0); else passed++;
    checks++; if (cc0 !== 16'd0) $display("FAIL go_count_clear: got %0d required 0", cc0); else passed++;
    checks++; if (prog_len0 !== 11'd4) $display("FAIL go_prog_len: got %0d required 4", prog_len0); else passed++;
    @(posedge CLK); #1;
    checks++; if (cpu_start0 !== 1'b1) $display("FAIL go_start2: got %b required 1", cpu_start0); else passed++;
    @(posedge CLK); #1;
    checks++; if (cpu_start0 !== 1'b0) $display("FAIL go_run: got %b required 0", cpu_start0); else passed++;
    repeat (5) @(posedge CLK);
    #1;
    halt0 = 1'b1;
    @(posedge CLK); #1;
    halt0 = 1'b0;
    checks++; if (done0 !== 1'b1 || cc0 !== 16'd5) $display("FAIL go_rerun_done: got done=%b count=%0d required 1 5", done0, cc0); else passed++;
  endtask

  task automatic test_overflow();
    logic [8:0] d;
    for (int i = 0; i < 10; i++) begin
      d = 9'(i * 37 + 5);
      lif1.load_valid = 1'b1;
      lif1.load_data  = d;
      lif1.load_last  = 1'b0;
      if (i < 8) exp1.push_back({3'(i), d});
      @(negedge CLK);
      checks++; if (lif1.load_ready !== (i < 8)) $display("FAIL ovf_ready_%0d: got %b required %b", i, lif1.load_ready, (i < 8)); else passed++;
      @(posedge CLK); #1;
      if (i == 7) begin
        checks++; if (overflow1 !== 1'b1) $display("FAIL ovf_flag: got %b required 1", overflow1); else passed++;
        checks++; if (prog_len1 !== 4'd8) $display("FAIL ovf_prog_len: got %0d required 8", prog_len1); else passed++;
        checks++; if (cpu_start1 !== 1'b1 || busy1 !== 1'b1) $display("FAIL ovf_start: got start=%b busy=%b required 1 1", cpu_start1, busy1); else passed++;
      end
    end
    lif1.load_valid = 1'b0;
    checks++; if (cpu_start1 !== 1'b0) $display("FAIL ovf_run: got start=%b required 0", cpu_start1); else passed++;
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    while (!done1 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++; if (done1 !== 1'b1) $display("FAIL to_done: got %b required 1 within 100 cycles", done1); else passed++;
    checks++; if (n != 21) $display("FAIL to_latency: got %0d cycles required 21", n); else passed++;
    checks++; if (timeout1 !== 1'b1) $display("FAIL to_flag: got %b required 1", timeout1); else passed++;
    checks++; if (cc1 !== 16'd20) $display("FAIL to_count: got %0d required 20", cc1); else passed++;
    checks++; if (cpu_start1 !== 1'b0 || overflow1 !== 1'b1) $display("FAIL to_start_ovf: got start=%b ovf=%b required 0 1", cpu_start1, overflow1); else passed++;
  endtask

  task automatic test_back_to_back();
    lif0.load_valid = 1'b1;
    lif0.load_data  = 9'h055;
    lif0.load_last  = 1'b1;
    go0 = 1'b1;
    exp0.push_back({10'd0, 9'h055});
    @(posedge CLK); #1;
    lif0.load_valid = 1'b0;
    lif0.load_last  = 1'b0;
    go0 = 1'b0;
    checks++; if (prog_len0 !== 11'd1) $display("FAIL b2b_prog_len: got %0d required 1", prog_len0); else passed++;
    checks++; if (cpu_start0 !== 1'b1 || cc0 !== 16'd0) $display("FAIL b2b_start: got start=%b count=%0d required 1 0", cpu_start0, cc0); else passed++;
    checks++; if (overflow0 !== 1'b0) $display("FAIL b2b_overflow: got %b required 0", overflow0); else passed++;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (cpu_start0 !== 1'b0 || busy0 !== 1'b1) $display("FAIL b2b_run: got start=%b busy=%b required 0 1", cpu_start0, busy0); else passed++;
  endtask

  task automatic test_reset_mid_run();
    repeat (12) @(posedge CLK);
    #1;
    checks++; if (cc0 !== 16'd12) $display("FAIL mid_pre_count: got %0d required 12", cc0); else passed++;
    reset_n = 1'b0;
    #1;
    checks++; if (cpu_start0 !== 1'b1) $display("FAIL mid_cpu_start: got %b required 1", cpu_start0); else passed++;
    checks++; if (cc0 !== 16'd0) $display("FAIL mid_count: got %0d required 0", cc0); else passed++;
    checks++; if (done0 !== 1'b0 || busy0 !== 1'b0) $display("FAIL mid_status: got done=%b busy=%b required 0 0", done0, busy0); else passed++;
    checks++; if (lif0.load_ready !== 1'b1) $display("FAIL mid_ready: got %b required 1", lif0.load_ready); else passed++;
    checks++; if (prog_len0 !== 11'd0) $display("FAIL mid_prog_len: got %0d required 0", prog_len0); else passed++;
    @(posedge CLK); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    lif0.load_valid = 1'b0; lif0.load_data = '0; lif0.load_last = 1'b0;
    lif1.load_valid = 1'b0; lif1.load_data = '0; lif1.load_last = 1'b0;
    halt0 = 1'b0; go0 = 1'b0;
    halt1 = 1'b0; go1 = 1'b0;
    test_reset();
    test_load();
    test_halt();
    test_go();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_reset_mid_run();
    checks++; if (exp0.size() != 0) $display("FAIL sb0_drain: got %0d pending writes required 0", exp0.size()); else passed++;
    checks++; if (exp1.size() != 0) $display("FAIL sb1_drain: got %0d pending writes required 0", exp1.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
